// File: rtl/dcp_arb_unit.sv
// dcp_arb_unit: round-robin merge of INUM Decoupled streams through a 2-entry output buffer.
// Define DCP_ARB_BURST_EN to enable burst lock (up to BURST consecutive beats per owner).
module dcp_arb_unit #(
   parameter int DW    = 16,
   parameter int AW    = 4,
   parameter int INUM  = 4,
   parameter int BURST = 4
) (
   input  logic                    iClk,
   input  logic                    iRst,
   input  logic [INUM-1:0]         iDcpInVld,
   output logic [INUM-1:0]         iDcpInRdy,
   input  logic [INUM-1:0][DW-1:0] iDcpInPld,
   input  logic [INUM-1:0][AW-1:0] iDcpInDst,
   output logic                    oDcpOutVld,
   input  logic                    oDcpOutRdy,
   output logic [DW-1:0]           oDcpOutPld,
   output logic [AW-1:0]           oDcpOutDst
);
   localparam int PW = $clog2(INUM);

   if (INUM < 2 || INUM > 16) begin : gBadInum
      $error("dcp_arb_unit: INUM must be 2..16");
   end
   if (BURST < 1 || BURST > 255) begin : gBadBurst
      $error("dcp_arb_unit: BURST must be 1..255");
   end

   // First valid input at or above start, wrapping; MSB flags that one was found.
   function automatic logic [PW:0] rrPick(input logic [INUM-1:0] vld, input logic [PW-1:0] start);
      logic [PW:0]   res;
      logic [PW-1:0] sel;
      res = '0;
      for (int i = INUM - 1; i >= 0; i--) begin
         sel = PW'((int'(start) + i) % INUM);
         if (vld[sel]) res = {1'b1, sel};
      end
      return res;
   endfunction

   function automatic logic [PW-1:0] nextIdx(input logic [PW-1:0] idx);
      return (int'(idx) == INUM - 1) ? '0 : idx + PW'(1);
   endfunction

   logic [DW-1:0] bufPld [2];
   logic [AW-1:0] bufDst [2];
   logic          wrIdx;
   logic          rdIdx;
   logic [1:0]    cnt;
   logic          space;
   logic          push;
   logic          pop;

   logic [PW-1:0] ptr;
   logic [PW-1:0] ptrNxt;
   logic [PW-1:0] gnt;
   logic [PW:0]   pick;
   logic          anyGnt;

   // Space comes from registered occupancy only, so output Rdy never reaches input Rdy.
   assign space      = (cnt != 2'd2);
   assign pop        = oDcpOutVld & oDcpOutRdy;
   assign oDcpOutVld = (cnt != 2'd0);
   assign oDcpOutPld = bufPld[rdIdx];
   assign oDcpOutDst = bufDst[rdIdx];

`ifdef DCP_ARB_BURST_EN
   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } stateT;

   stateT         state;
   stateT         stateNxt;
   logic [PW-1:0] owner;
   logic [PW-1:0] ownerNxt;
   logic [7:0]    bcnt;
   logic [7:0]    bcntNxt;
   logic          lockHold;

   // A lock whose owner has dropped Vld falls back to plain arbitration in the same cycle.
   assign lockHold = (state == LOCK) && iDcpInVld[owner];
`endif

   always_comb begin
      pick   = rrPick(iDcpInVld, ptr);
      gnt    = pick[PW-1:0];
      anyGnt = pick[PW];
`ifdef DCP_ARB_BURST_EN
      if (lockHold) begin
         gnt    = owner;
         anyGnt = 1'b1;
      end
`endif
      push      = anyGnt & space & ~iRst;
      iDcpInRdy = '0;
      if (push) iDcpInRdy[gnt] = 1'b1;
   end

   always_comb begin
      ptrNxt = ptr;
`ifdef DCP_ARB_BURST_EN
      stateNxt = state;
      ownerNxt = owner;
      bcntNxt  = bcnt;
      if (push && lockHold) begin
         bcntNxt = bcnt + 8'd1;
         if (bcntNxt == 8'(BURST)) stateNxt = IDLE;
      end else if (push) begin
         ptrNxt = nextIdx(gnt);
         if (BURST > 1) begin
            stateNxt = LOCK;
            ownerNxt = gnt;
            bcntNxt  = 8'd1;
         end else begin
            stateNxt = IDLE;
         end
      end else if (space && !lockHold) begin
         stateNxt = IDLE;
      end
`else
      if (push) ptrNxt = nextIdx(gnt);
`endif
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         ptr   <= '0;
`ifdef DCP_ARB_BURST_EN
         state <= IDLE;
         owner <= '0;
         bcnt  <= '0;
`endif
      end else begin
         ptr   <= ptrNxt;
`ifdef DCP_ARB_BURST_EN
         state <= stateNxt;
         owner <= ownerNxt;
         bcnt  <= bcntNxt;
`endif
      end
   end

   // Output buffer stage: occupancy and pointers reset, entry contents do not.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         cnt   <= 2'd0;
         wrIdx <= 1'b0;
         rdIdx <= 1'b0;
      end else begin
         if (push) wrIdx <= ~wrIdx;
         if (pop) rdIdx <= ~rdIdx;
         case ({push, pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge iClk) begin
      if (push) begin
         bufPld[wrIdx] <= iDcpInPld[gnt];
         bufDst[wrIdx] <= iDcpInDst[gnt];
      end
   end
endmodule

// File: tb/tb_dcp_arb_unit.sv
// tb_dcp_arb_unit: directed scoreboard bench for dcp_arb_unit; the expected grant order
// follows whether DCP_ARB_BURST_EN is defined (burst lock) or not (per-beat round robin).
`timescale 1ns/1ps
module tb_dcp_arb_unit;
   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int INUM  = 4;
   localparam int BURST = 4;
   localparam int PW    = 2;

   logic                    iClk = 1'b0;
   logic                    iRst;
   logic [INUM-1:0]         inVld;
   logic [INUM-1:0]         inRdy;
   logic [INUM-1:0][DW-1:0] inPld;
   logic [INUM-1:0][AW-1:0] inDst;
   logic                    outVld;
   logic                    outRdy;
   logic [DW-1:0]           outPld;
   logic [AW-1:0]           outDst;

   dcp_arb_unit #(.DW(DW), .AW(AW), .INUM(INUM), .BURST(BURST)) dut (
      .iClk      (iClk),
      .iRst      (iRst),
      .iDcpInVld (inVld),
      .iDcpInRdy (inRdy),
      .iDcpInPld (inPld),
      .iDcpInDst (inDst),
      .oDcpOutVld(outVld),
      .oDcpOutRdy(outRdy),
      .oDcpOutPld(outPld),
      .oDcpOutDst(outDst)
   );

   always #5 iClk = ~iClk;

   typedef struct packed {
      logic [DW-1:0] pld;
      logic [AW-1:0] dst;
   } beatT;

   beatT expQ[$];
   beatT monE;
   int   cmpCnt   = 0;
   int   errCnt   = 0;
   int   popCnt   = 0;
   int   cycCnt   = 0;
   int   firstPop = -1;
   int   lastPop  = -1;
   int   srcLeft[INUM];
   int   srcSeq[INUM];
   int   expSeq[INUM];
   logic probe = 1'b0;
   int   base;

   function automatic beatT mkBeat(input int k, input int s);
      beatT b;
      b.pld = {4'(k), 12'(s)};
      b.dst = AW'(k * 5 + s);
      return b;
   endfunction

   task automatic check(input string name, input int act, input int req);
      cmpCnt++;
      if (act != req) begin
         errCnt++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic drive();
      beatT          b;
      logic [PW-1:0] kk;
      for (int k = 0; k < INUM; k++) begin
         kk        = PW'(k);
         b         = mkBeat(k, srcSeq[k]);
         inVld[kk] = (srcLeft[k] > 0);
         inPld[kk] = b.pld;
         inDst[kk] = b.dst;
      end
   endtask

   // Source order is listed one nibble per beat, oldest in the most significant nibble.
   task automatic expectList(input logic [127:0] list, input int n);
      int k;
      for (int i = 0; i < n; i++) begin
         k = int'(list[4*(n-1-i) +: 4]);
         expQ.push_back(mkBeat(k, expSeq[k]));
         expSeq[k]++;
      end
   endtask

   task automatic cycle();
      logic [INUM-1:0] acc;
      logic [INUM-1:0] rA;
      logic [PW-1:0]   kk;
      @(negedge iClk);
      #1;
      if (probe) begin
         rA     = inRdy;
         outRdy = ~outRdy;
         #1;
         check("rdy_isolation", int'(inRdy), int'(rA));
         outRdy = ~outRdy;
         #1;
      end
      acc = inVld & inRdy;
      @(posedge iClk);
      #1;
      for (int k = 0; k < INUM; k++) begin
         kk = PW'(k);
         if (acc[kk]) begin
            srcSeq[k]++;
            srcLeft[k]--;
         end
      end
      drive();
   endtask

   task automatic runUntil(input string name, input int target, input int budget);
      int n;
      n = 0;
      while (popCnt < target && n < budget) begin
         cycle();
         n++;
      end
      check({name, "_beats"}, popCnt, target);
   endtask

   initial forever begin
      @(posedge iClk);
      cycCnt++;
   end

   initial forever begin
      @(negedge iClk);
      if (!iRst && outVld && outRdy) begin
         popCnt++;
         if (firstPop < 0) firstPop = cycCnt;
         lastPop = cycCnt;
         cmpCnt++;
         if (expQ.size() == 0) begin
            errCnt++;
            $display("FAIL out_unexpected: pld=%h dst=%h, required no beat", outPld, outDst);
         end else begin
            monE = expQ.pop_front();
            if (outPld !== monE.pld || outDst !== monE.dst) begin
               errCnt++;
               $display("FAIL out_beat: pld=%h dst=%h, required pld=%h dst=%h",
                        outPld, outDst, monE.pld, monE.dst);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      iRst   = 1'b1;
      outRdy = 1'b0;
      for (int k = 0; k < INUM; k++) begin
         srcLeft[k] = 100;
         srcSeq[k]  = 0;
         expSeq[k]  = 0;
      end
      drive();
      repeat (3) cycle();
      check("rst_out_vld", int'(outVld), 0);
      check("rst_in_rdy", int'(inRdy), 0);

      // Fill the buffer (lock active in the burst build), then reset on top of it.
      iRst = 1'b0;
      repeat (4) cycle();
`ifdef DCP_ARB_BURST_EN
      check("fill_src0", srcSeq[0], 2);
      check("fill_src1", srcSeq[1], 0);
      expSeq[0] = 2;
`else
      check("fill_src0", srcSeq[0], 1);
      check("fill_src1", srcSeq[1], 1);
      expSeq[0] = 1;
      expSeq[1] = 1;
`endif
      check("full_in_rdy", int'(inRdy), 0);
      check("full_out_vld", int'(outVld), 1);
      iRst = 1'b1;
      cycle();
      check("rst2_out_vld", int'(outVld), 0);
      check("rst2_in_rdy", int'(inRdy), 0);
      check("rst2_no_accept", srcSeq[0] + srcSeq[1] + srcSeq[2] + srcSeq[3], 2);

      // Full contention.
      srcLeft[0] = 5;
      srcLeft[1] = 4;
      srcLeft[2] = 4;
      srcLeft[3] = 4;
      drive();
      outRdy = 1'b1;
      iRst   = 1'b0;
      #1;
      check("rel_first_gnt", int'(inRdy), 1);
`ifdef DCP_ARB_BURST_EN
      expectList(128'h00001111222233330, 17);
`else
      expectList(128'h01230123012301230, 17);
`endif
      popCnt   = 0;
      firstPop = -1;
      runUntil("contention", 17, 60);
      check("contention_rate", lastPop - firstPop, 16);
      repeat (3) cycle();

      // Early lock release: input 1 runs out while input 3 waits.
      srcLeft[1] = 2;
      srcLeft[3] = 3;
      drive();
`ifdef DCP_ARB_BURST_EN
      expectList(128'h11333, 5);
`else
      expectList(128'h13133, 5);
`endif
      popCnt   = 0;
      firstPop = -1;
      runUntil("early_rel", 5, 30);
      check("early_rel_rate", lastPop - firstPop, 4);
      repeat (2) cycle();
      srcLeft[0] = 1;
      srcLeft[2] = 1;
      drive();
      #1;
      check("ptr_after_rel", int'(inRdy), 1);
      expectList(128'h02, 2);
      popCnt = 0;
      runUntil("ptr_wrap", 2, 20);
      repeat (2) cycle();

      // Output stall with input 2 valid.
      outRdy     = 1'b0;
      srcLeft[2] = 6;
      drive();
      base = srcSeq[2];
      repeat (10) cycle();
      check("stall_accepted", srcSeq[2] - base, 2);
      check("stall_in_rdy", int'(inRdy), 0);
      expectList(128'h222222, 6);
      popCnt = 0;
      outRdy = 1'b1;
      runUntil("stall_drain", 6, 30);
      repeat (2) cycle();

      // Output Rdy toggling every cycle with isolation probing.
      srcLeft[0] = 3;
      srcLeft[1] = 3;
      drive();
`ifdef DCP_ARB_BURST_EN
      expectList(128'h000111, 6);
`else
      expectList(128'h010101, 6);
`endif
      popCnt = 0;
      probe  = 1'b1;
      for (int n = 0; n < 60 && popCnt < 6; n++) begin
         outRdy = ~outRdy;
         cycle();
      end
      probe = 1'b0;
      check("toggle_beats", popCnt, 6);
      outRdy = 1'b1;
      repeat (3) cycle();
      check("queue_empty", expQ.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
      $finish;
   end
endmodule
